dll_rx_ack_nak: RTL and testbench
=================================

# dll_rx_ack_nak

Receive-side data link layer sequence checker and ACK/NAK generator, the link-partner counterpart of the transmit replay buffer. It accepts 16-bit TLP words from the physical-layer deframer and checks the 12-bit sequence number and the externally computed LCRC result. It forwards accepted TLPs to the transaction layer with a commit/abort marker, and produces the ack_nack/seq DLLP requests that the transmitting replay buffer consumes.

## Interface
- ACK_LAT, 16, cycles from first unacknowledged good TLP to a coalesced ACK request (2..255)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  rx word valid
- rx_sop  in  1  first word of TLP; rx_data[11:0] = sequence number, [15:12] reserved
- rx_eop  in  1  last word of TLP
- rx_data  in  16  TLP word
- rx_crc_ok  in  1  LCRC good; sampled only with rx_valid & rx_eop
- tl_valid  out  1  forwarded word valid
- tl_sop / tl_eop  out  1 each  forwarded framing
- tl_data  out  16  forwarded word
- tl_commit  out  1  one-cycle pulse: TLP just ended is good
- tl_abort  out  1  one-cycle pulse: TLP just ended must be discarded
- ack_nack  out  2  00 none, 01 ACK, 10 NAK (11 never driven)
- ack_seq  out  12  sequence number carried by the DLLP
- dllp_ready  in  1  DLLP transmitter accepts the current request
- next_rcv_seq  out  12  expected sequence number (status)

## Operation
- FSM: IDLE, BODY.
  - IDLE → BODY on rx_valid & rx_sop & !rx_eop; the sequence number is captured.
  - BODY → IDLE on rx_valid & rx_eop.
  - rx_valid & rx_sop & rx_eop (one-word TLP) is malformed: abort, NAK rule applies.
  - rx_sop while in BODY: abort the current TLP (NAK rule), then start the new one; state stays BODY.
  - Words with rx_valid low are ignored.
- Classification at eop. d = (next_rcv_seq − seq) mod 4096:
  - rx_crc_ok=0 → BAD.
  - Otherwise d=0 → GOOD.
  - Otherwise d in 1..2048 → DUP.
  - Otherwise → OOS.
- GOOD: tl_commit, next_rcv_seq += 1 (12-bit wrap, 4095→0), nak_scheduled cleared, ACK timer started if idle.
- DUP: tl_abort, immediate ACK request, next_rcv_seq unchanged.
- BAD/OOS: tl_abort. If !nak_scheduled, issue a NAK request and set nak_scheduled; otherwise issue nothing.
- DLLP request register:
  - ack_nack/ack_seq are held stable until dllp_ready is sampled high, then cleared next cycle.
  - ack_seq = next_rcv_seq − 1 at the cycle the request is loaded, using the post-update value.
  - NAK has priority: a NAK overwrites a pending, unaccepted ACK. An ACK arriving while a NAK is pending is dropped.
  - Any ACK or NAK load stops and clears the ACK timer.
- ACK timer: counts while running. At count ACK_LAT−1 it loads an ACK request; if a request is already pending, the timer holds at terminal count until the register frees.
- Forwarding: rx words are registered into tl_* unconditionally (including DUP/BAD/OOS TLPs). The transaction layer discards on tl_abort.

## Timing
- Reset values: all outputs 0; next_rcv_seq=0; FSM IDLE; nak_scheduled=0; timer idle; no request pending.
- tl_* = rx_* delayed 1 cycle.
- tl_commit/tl_abort pulse in the same cycle as tl_eop, i.e. eop+1.
- Sequence and flag updates take effect at the eop clock edge. Back-to-back TLPs (sop the cycle after eop) are supported with no bubble.
- DUP ACK and NAK requests are visible on ack_nack at eop+1.
- A coalesced ACK becomes visible ACK_LAT cycles after the first GOOD eop+1.
- A simultaneous eop-driven request and dllp_ready acceptance: acceptance retires the old request, and the new request appears next cycle without loss.
- Reset assertion mid-TLP clears everything asynchronously. No commit or abort is emitted for the truncated TLP.

## Structure
- Shared package dll_pkg: ACK_NAK_NONE/ACK/NAK encodings, SEQ_W=12, SEQ_HALF=2048, and a seq_class_e enum (GOOD, DUP, BAD, OOS).
- One sub-module: dll_ack_timer (counter with start/clear/terminal-hold). Classification, FSM and request register live in the top module.

## Test plan
- Reset, then TLPs seq 0,1,2 (4 words each, crc_ok=1) back-to-back, ACK_LAT=16, dllp_ready=1 → three tl_commit pulses; one ACK with ack_seq=2 appearing 16 cycles after the first eop+1; next_rcv_seq=3.
- After that, resend seq 1 → tl_abort; immediate ACK with ack_seq=2 at eop+1.
- next_rcv_seq=3, TLP seq 3 with crc_ok=0 then seq 4 crc_ok=1 → two aborts, exactly one NAK with ack_seq=2; a following good seq 3 commits and clears nak_scheduled.
- Hold dllp_ready=0 for 10 cycles with an ACK pending, then a BAD TLP → ACK replaced by NAK, held stable until dllp_ready=1, cleared next cycle.
- Preload 4095 good TLPs, then seq 4095 and seq 0 → both commit; next_rcv_seq wraps to 1; a subsequent seq 4095 classifies as DUP.
- Assert reset_n=0 mid-BODY → all outputs 0 immediately; the next sop with seq 0 commits.

Source files
------------

// File: rtl/dll_pkg.sv
// dll_pkg: shared DLL encodings, sequence constants and TLP sequence classification
package dll_pkg;
    localparam int SEQ_W = 12;
    localparam int SEQ_HALF = 2048;
    localparam logic [1:0] ACK_NAK_NONE = 2'b00;
    localparam logic [1:0] ACK_NAK_ACK = 2'b01;
    localparam logic [1:0] ACK_NAK_NAK = 2'b10;
    typedef enum logic [1:0] {SEQ_GOOD, SEQ_DUP, SEQ_BAD, SEQ_OOS} seq_class_e;
    function automatic seq_class_e classify(input logic [SEQ_W-1:0] expected, input logic [SEQ_W-1:0] seq, input logic crc_ok);
        logic [SEQ_W-1:0] d;
        d = expected - seq;
        return !crc_ok ? SEQ_BAD : d == '0 ? SEQ_GOOD : d <= SEQ_W'(SEQ_HALF) ? SEQ_DUP : SEQ_OOS;
    endfunction
endpackage

// File: rtl/dll_ack_timer.sv
// dll_ack_timer: ACK coalescing timer; start (if idle), clear, term high and held at ACK_LAT-1 until cleared
module dll_ack_timer #(
    parameter int ACK_LAT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    output logic term
);
    localparam logic [7:0] TERM = 8'(ACK_LAT - 1);
    logic       run;
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (clear) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start && !run) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run && cnt != TERM) begin
            cnt <= cnt + 8'd1;
        end
    assign term = run && cnt == TERM;
endmodule

// File: rtl/dll_rx_ack_nak.sv
// dll_rx_ack_nak: rx sequence checker; rx_* in, tl_* forwarded 1 cycle later with commit/abort, ack_nack/ack_seq DLLP request handshaked by dllp_ready
module dll_rx_ack_nak
    import dll_pkg::*;
#(
    parameter int ACK_LAT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic [15:0]       rx_data,
    input  logic              rx_crc_ok,
    output logic              tl_valid,
    output logic              tl_sop,
    output logic              tl_eop,
    output logic [15:0]       tl_data,
    output logic              tl_commit,
    output logic              tl_abort,
    output logic [1:0]        ack_nack,
    output logic [SEQ_W-1:0]  ack_seq,
    input  logic              dllp_ready,
    output logic [SEQ_W-1:0]  next_rcv_seq
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;
    logic [0:0]       state;
    logic [SEQ_W-1:0] cur_seq;
    logic [SEQ_W-1:0] seq_n;
    logic             nak_scheduled;
    logic             ended, good, dup, nak_load, ack_load, busy, nak_busy, tmr_term, tmr_fire;
    seq_class_e       cls;
    // A TLP ends at eop, or is cut short by a new sop; a sop-terminated or one-word TLP is always bad
    assign ended    = rx_valid && ((state == ST_BODY && (rx_sop || rx_eop)) || (rx_sop && rx_eop));
    assign cls      = rx_sop ? SEQ_BAD : classify(next_rcv_seq, cur_seq, rx_crc_ok);
    assign good     = ended && cls == SEQ_GOOD;
    assign dup      = ended && cls == SEQ_DUP;
    assign nak_load = ended && (cls == SEQ_BAD || cls == SEQ_OOS) && !nak_scheduled;
    // Acceptance this cycle frees the register, so a new request can load on the same edge
    assign busy     = ack_nack != ACK_NAK_NONE && !dllp_ready;
    assign nak_busy = ack_nack == ACK_NAK_NAK && !dllp_ready;
    assign tmr_fire = tmr_term && !busy;
    assign ack_load = (dup || tmr_fire) && !nak_load && !nak_busy;
    assign seq_n    = next_rcv_seq + {{(SEQ_W-1){1'b0}}, good};
    dll_ack_timer #(.ACK_LAT(ACK_LAT)) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (good),
        .clear  (nak_load || ack_load),
        .term   (tmr_term)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state         <= ST_IDLE;
            cur_seq       <= '0;
            next_rcv_seq  <= '0;
            nak_scheduled <= 1'b0;
            tl_valid      <= 1'b0;
            tl_sop        <= 1'b0;
            tl_eop        <= 1'b0;
            tl_data       <= '0;
            tl_commit     <= 1'b0;
            tl_abort      <= 1'b0;
            ack_nack      <= ACK_NAK_NONE;
            ack_seq       <= '0;
        end else begin
            tl_valid      <= rx_valid;
            tl_sop        <= rx_sop;
            tl_eop        <= rx_eop;
            tl_data       <= rx_data;
            tl_commit     <= good;
            tl_abort      <= ended && !good;
            next_rcv_seq  <= seq_n;
            nak_scheduled <= good ? 1'b0 : nak_load ? 1'b1 : nak_scheduled;
            state         <= (rx_valid && rx_sop && !rx_eop) ? ST_BODY : (rx_valid && rx_eop) ? ST_IDLE : state;
            if (rx_valid && rx_sop)
                cur_seq <= rx_data[SEQ_W-1:0];
            if (nak_load || ack_load) begin
                ack_nack <= nak_load ? ACK_NAK_NAK : ACK_NAK_ACK;
                ack_seq  <= seq_n - 12'd1;
            end else if (dllp_ready) begin
                ack_nack <= ACK_NAK_NONE;
                ack_seq  <= '0;
            end
        end
endmodule

// File: tb/tb_dll_rx_ack_nak.sv
// tb_dll_rx_ack_nak: randomized and directed self-checking bench against a transaction-level model
module tb_dll_rx_ack_nak;
    localparam int ACK_LAT = 16;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_crc_ok = 1'b0, dllp_ready = 1'b0;
    logic [15:0] rx_data = '0;
    logic        tl_valid, tl_sop, tl_eop, tl_commit, tl_abort;
    logic [15:0] tl_data;
    logic [1:0]  ack_nack;
    logic [11:0] ack_seq, next_rcv_seq;
    int checks = 0, errors = 0;
    int m_seq, m_cur, m_due, m_t = 0;
    bit m_in, m_nak, e_c, e_a;
    logic [1:0]  m_an, prev_an;
    logic [11:0] m_as;
    logic [18:0] e_tl;
    int n_commit, n_abort, n_ack, n_nak, last_seq, ack_cyc, abort_cyc, first_commit_cyc;

    dll_rx_ack_nak #(.ACK_LAT(ACK_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_data(rx_data), .rx_crc_ok(rx_crc_ok), .tl_valid(tl_valid), .tl_sop(tl_sop),
        .tl_eop(tl_eop), .tl_data(tl_data), .tl_commit(tl_commit), .tl_abort(tl_abort),
        .ack_nack(ack_nack), .ack_seq(ack_seq), .dllp_ready(dllp_ready), .next_rcv_seq(next_rcv_seq)
    );

    always #5 clk = ~clk;

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task model_reset();
        m_seq = 0; m_cur = 0; m_due = -1; m_in = 0; m_nak = 0;
        m_an = 0; m_as = 0; e_tl = 0; e_c = 0; e_a = 0; prev_an = 0;
    endtask

    task clr_mon();
        n_commit = 0; n_abort = 0; n_ack = 0; n_nak = 0;
        last_seq = -1; ack_cyc = -1; abort_cyc = -1; first_commit_cyc = -1;
    endtask

    // Expected effect of the coming clock edge, from the classification and request rules
    task model_edge();
        int d;
        bit ended, good, dup, bad, nakl, ackl, busy, fire;
        m_t++;
        ended = rx_valid && ((m_in && (rx_sop || rx_eop)) || (rx_sop && rx_eop));
        d = (m_seq - m_cur + 4096) % 4096;
        good = ended && !rx_sop && rx_crc_ok && d == 0;
        dup = ended && !rx_sop && rx_crc_ok && d >= 1 && d <= 2048;
        bad = ended && !good && !dup;
        busy = m_an != 0 && !dllp_ready;
        nakl = bad && !m_nak;
        fire = m_due >= 0 && m_t >= m_due && !busy;
        ackl = (dup || fire) && !nakl && !(m_an == 2 && !dllp_ready);
        if (good) begin
            m_seq = (m_seq + 1) % 4096;
            m_nak = 0;
        end
        if (nakl) m_nak = 1;
        if (nakl || ackl) begin
            m_an = nakl ? 2'd2 : 2'd1;
            m_as = 12'((m_seq + 4095) % 4096);
            m_due = -1;
        end else begin
            if (dllp_ready) begin
                m_an = 0;
                m_as = 0;
            end
            if (good && m_due < 0) m_due = m_t + ACK_LAT;
        end
        if (rx_valid && rx_sop) m_cur = int'(rx_data[11:0]);
        m_in = (rx_valid && rx_sop && !rx_eop) ? 1'b1 : (rx_valid && rx_eop) ? 1'b0 : m_in;
        e_tl = {rx_valid, rx_sop, rx_eop, rx_data};
        e_c = good;
        e_a = ended && !good;
    endtask

    task step(input bit v, input bit s, input bit e, input logic [15:0] dat, input bit crc, input bit rdy);
        rx_valid = v; rx_sop = s; rx_eop = e; rx_data = dat; rx_crc_ok = crc; dllp_ready = rdy;
        model_edge();
        @(negedge clk);
        chk("tl", {13'd0, tl_valid, tl_sop, tl_eop, tl_data}, {13'd0, e_tl});
        chk("cmt_abt", {30'd0, tl_commit, tl_abort}, {30'd0, e_c, e_a});
        chk("dllp", {18'd0, ack_nack, ack_seq}, {18'd0, m_an, m_as});
        chk("nrs", {20'd0, next_rcv_seq}, 32'(m_seq));
        if (tl_commit) begin
            n_commit++;
            if (first_commit_cyc < 0) first_commit_cyc = m_t;
        end
        if (tl_abort) begin
            n_abort++;
            abort_cyc = m_t;
        end
        if (ack_nack != 0 && (prev_an == 0 || rdy || prev_an != ack_nack)) begin
            if (ack_nack == 2'd1) n_ack++; else n_nak++;
            last_seq = int'(ack_seq);
            ack_cyc = m_t;
        end
        prev_an = ack_nack;
    endtask

    task idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'd0, 0, rdy);
    endtask

    task send(input int seq, input int len, input bit crc, input bit rdy, input bit trunc, input bit rnd);
        logic [11:0] sq;
        sq = 12'(seq);
        for (int i = 0; i < len; i++) begin
            if (rnd && $urandom_range(0, 3) == 0)
                step(0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
            step(1, i == 0, (i == len - 1) && !trunc, i == 0 ? {4'($urandom), sq} : 16'($urandom), crc,
                 rnd ? $urandom_range(0, 3) != 0 : rdy);
        end
    endtask

    initial begin
        int sel, sq;
        model_reset();
        clr_mon();
        repeat (3) @(negedge clk);
        chk("reset_out", {ack_nack, tl_valid, tl_commit, tl_abort, next_rcv_seq}, 32'd0);
        reset_n = 1'b1;
        // back-to-back good TLPs, coalesced ACK
        send(0, 4, 1, 1, 0, 0);
        send(1, 4, 1, 1, 0, 0);
        send(2, 4, 1, 1, 0, 0);
        idle(24, 1);
        chk("t1_commits", n_commit, 3);
        chk("t1_acks", n_ack, 1);
        chk("t1_ack_seq", last_seq, 2);
        chk("t1_ack_lat", ack_cyc - first_commit_cyc, ACK_LAT);
        chk("t1_nrs", {20'd0, next_rcv_seq}, 3);
        // duplicate gets immediate ACK
        clr_mon();
        send(1, 4, 1, 1, 0, 0);
        idle(2, 1);
        chk("t2_abort", n_abort, 1);
        chk("t2_ack", n_ack, 1);
        chk("t2_ack_seq", last_seq, 2);
        chk("t2_ack_time", ack_cyc, abort_cyc);
        // bad then OOS: one NAK
        clr_mon();
        send(3, 4, 0, 1, 0, 0);
        send(4, 4, 1, 1, 0, 0);
        idle(2, 1);
        chk("t3_aborts", n_abort, 2);
        chk("t3_naks", n_nak, 1);
        chk("t3_nak_seq", last_seq, 2);
        clr_mon();
        send(3, 4, 1, 1, 0, 0);
        idle(2, 1);
        chk("t3_commit", n_commit, 1);
        // pending ACK replaced by NAK while dllp_ready is low
        send(1, 2, 1, 0, 0, 0);
        idle(10, 0);
        chk("t4_ack_pend", {ack_nack, ack_seq}, {2'd1, 12'd3});
        clr_mon();
        send(5, 2, 0, 0, 0, 0);
        idle(3, 0);
        chk("t4_nak_pend", {ack_nack, ack_seq}, {2'd2, 12'd3});
        chk("t4_nak_cnt", n_nak, 1);
        idle(1, 1);
        chk("t4_cleared", {30'd0, ack_nack}, 0);
        // reset in the middle of a TLP
        step(1, 1, 0, 16'h0004, 1, 1);
        step(1, 0, 0, 16'h1234, 1, 1);
        rx_valid = 0; rx_sop = 0; rx_eop = 0; rx_data = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_flags", {25'd0, tl_valid, tl_sop, tl_eop, tl_commit, tl_abort, ack_nack}, 0);
        chk("rst_data", {tl_data, 4'd0, ack_seq}, 0);
        chk("rst_nrs", {20'd0, next_rcv_seq}, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        clr_mon();
        send(0, 3, 1, 1, 0, 0);
        idle(2, 1);
        chk("t6_commit", n_commit, 1);
        chk("t6_abort", n_abort, 0);
        // sequence wrap
        for (int s = 1; s < 4095; s++) send(s, 2, 1, 1, 0, 0);
        clr_mon();
        send(4095, 2, 1, 1, 0, 0);
        send(0, 2, 1, 1, 0, 0);
        idle(1, 1);
        chk("t5_commits", n_commit, 2);
        chk("t5_nrs", {20'd0, next_rcv_seq}, 1);
        clr_mon();
        send(4095, 2, 1, 1, 0, 0);
        idle(2, 1);
        chk("t5_dup_abort", n_abort, 1);
        chk("t5_dup_ack_seq", last_seq, 0);
        chk("t5_dup_nocommit", n_commit, 0);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            sq = sel < 6 ? m_seq : sel < 8 ? m_seq - $urandom_range(1, 2048) : sel < 9 ? m_seq + $urandom_range(1, 2047) : $urandom_range(0, 4095);
            send((sq + 8192) % 4096, $urandom_range(1, 5), $urandom_range(0, 7) != 0, 1, $urandom_range(0, 9) == 0, 1);
            for (int g = $urandom_range(0, 2); g > 0; g--)
                step(0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end
        idle(40, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
